debounce_edge: RTL and testbench

Parametrised multi-channel debouncer and edge trigger for raw push-button and switch inputs. Each channel synchronises its asynchronous input, filters it with a stability counter, and produces a clean level plus a one-cycle edge pulse qualified by a per-channel mode. Sticky per-channel event flags are held until software clears them. The block sits between the board pins and the control logic. It runs on a single rising clock edge.

---
 rtl/debounce_pkg.sv | 11 +
 rtl/debounce_channel.sv | 66 ++++++
 rtl/debounce_edge.sv | 47 ++++
 tb/tb_debounce_edge.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and constants for the debounce_edge block.
package debounce_pkg;

  typedef logic [1:0] edge_mode_t;

  localparam edge_mode_t MODE_OFF  = 2'b00;
  localparam edge_mode_t MODE_RISE = 2'b01;
  localparam edge_mode_t MODE_FALL = 2'b10;
  localparam edge_mode_t MODE_BOTH = 2'b11;

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: 2-flop synchroniser, stability counter, debounced
// level, mode-qualified edge pulse and sticky event flag.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       in,
  input  edge_mode_t mode,
  input  logic       clear,
  output logic       level,
  output logic       out,
  output logic       flag,
  output logic       pulse_c
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;
  logic             flip_c;
  logic             rise_en_c;
  logic             fall_en_c;

  // A flip is due when the synchronised input has disagreed for the full window.
  always_comb begin
    flip_c    = 1'b0;
    rise_en_c = 1'b0;
    fall_en_c = 1'b0;
    pulse_c   = 1'b0;
    rise_en_c = (mode == MODE_RISE) || (mode == MODE_BOTH);
    fall_en_c = (mode == MODE_FALL) || (mode == MODE_BOTH);
    flip_c    = (s2 != level) && (cnt == CNT_MAX);
    pulse_c   = flip_c && (level ? fall_en_c : rise_en_c);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      out   <= 1'b0;
      flag  <= 1'b0;
    end else begin
      s1  <= in;
      s2  <= s1;
      out <= pulse_c;
      if (s2 == level) begin
        cnt <= '0;
      end else if (flip_c) begin
        cnt   <= '0;
        level <= ~level;
      end else begin
        cnt <= CNT_W'(cnt + 1'b1);
      end
      // Set beats a coincident clear.
      flag <= pulse_c | (flag & ~clear);
    end
  end

endmodule

// File: rtl/debounce_edge.sv
// Multi-channel debouncer and edge trigger; one debounce_channel per input
// plus a registered OR of all edge pulses.
module debounce_edge
  import debounce_pkg::*;
#(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned STABLE_CYCLES = 16
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [CHANNELS-1:0]     in,
  input  logic [2*CHANNELS-1:0]   mode,
  input  logic [CHANNELS-1:0]     clear,
  output logic [CHANNELS-1:0]     level,
  output logic [CHANNELS-1:0]     out,
  output logic [CHANNELS-1:0]     flags,
  output logic                    event_any
);

  logic [CHANNELS-1:0] pulse_c;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES (STABLE_CYCLES)
    ) u_ch (
      .clock   (clock),
      .reset_n (reset_n),
      .in      (in[i]),
      .mode    (edge_mode_t'(mode[2*i +: 2])),
      .clear   (clear[i]),
      .level   (level[i]),
      .out     (out[i]),
      .flag    (flags[i]),
      .pulse_c (pulse_c[i])
    );
  end

  // Registered from the same pulse terms so it aligns with out.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      event_any <= 1'b0;
    end else begin
      event_any <= |pulse_c;
    end
  end

endmodule

// File: tb/tb_debounce_edge.sv
// Directed self-checking bench for debounce_edge (4 channels, 4-cycle window).
module tb_debounce_edge;

  logic       clock;
  logic       reset_n;
  logic [3:0] in;
  logic [7:0] mode;
  logic [3:0] clear;
  logic [3:0] level;
  logic [3:0] out;
  logic [3:0] flags;
  logic       event_any;

  int checks;
  int failures;

  debounce_edge #(
    .CHANNELS      (4),
    .STABLE_CYCLES (4)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in        (in),
    .mode      (mode),
    .clear     (clear),
    .level     (level),
    .out       (out),
    .flags     (flags),
    .event_any (event_any)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Apply a new input and check nothing moves before E0+5, then check the flip.
  task automatic run_edge(input string tag, input logic [3:0] new_in, input logic [3:0] prev_level,
                          input logic [3:0] exp_level, input logic [3:0] exp_out,
                          input logic [3:0] exp_flags);
    in = new_in;
    tick(5);
    check({tag, ".hold_level"}, 32'(level), 32'(prev_level));
    check({tag, ".hold_out"}, 32'(out), 32'(0));
    tick(1);
    check({tag, ".level"}, 32'(level), 32'(exp_level));
    check({tag, ".out"}, 32'(out), 32'(exp_out));
    check({tag, ".event_any"}, 32'(event_any), 32'(exp_out != 4'h0));
    check({tag, ".flags"}, 32'(flags), 32'(exp_flags));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    in       = 4'hF;
    mode     = 8'h55;
    clear    = 4'h0;

    // 1. Reset with inputs high, then full-latency rise on all channels.
    tick(3);
    check("rst.level", 32'(level), 32'(0));
    check("rst.out", 32'(out), 32'(0));
    check("rst.flags", 32'(flags), 32'(0));
    check("rst.event_any", 32'(event_any), 32'(0));
    reset_n = 1'b1;
    run_edge("rst_rise", 4'hF, 4'h0, 4'hF, 4'hF, 4'hF);
    tick(1);
    check("rst_rise.pulse_end", 32'(out), 32'(0));
    check("rst_rise.any_end", 32'(event_any), 32'(0));
    clear = 4'hF;
    tick(1);
    check("clear_all", 32'(flags), 32'(0));
    clear = 4'h0;

    // 2. Channel 0 in both-edge mode: fall then rise.
    mode = 8'h57;
    run_edge("ch0_fall", 4'hE, 4'hF, 4'hE, 4'h1, 4'h1);
    tick(1);
    check("ch0_fall.pulse_end", 32'(out), 32'(0));
    run_edge("ch0_rise", 4'hF, 4'hE, 4'hF, 4'h1, 4'h1);
    tick(1);
    check("ch0_rise.pulse_end", 32'(out), 32'(0));

    // Mode off: level follows the input, no pulse, no flag.
    clear = 4'hF;
    tick(1);
    clear = 4'h0;
    mode  = 8'h00;
    run_edge("off_fall", 4'h0, 4'hF, 4'h0, 4'h0, 4'h0);

    // 3. Three-cycle glitch on channel 1 must be rejected.
    mode = 8'h55;
    in   = 4'h2;
    tick(3);
    in = 4'h0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("glitch.level", 32'(level[1]), 32'(0));
      check("glitch.out", 32'(out[1]), 32'(0));
    end
    check("glitch.flags", 32'(flags), 32'(0));

    // 4. Channel 2 fall-only: rise tracks silently, fall pulses.
    mode = 8'h20;
    run_edge("ch2_rise", 4'h4, 4'h0, 4'h4, 4'h0, 4'h0);
    run_edge("ch2_fall", 4'h0, 4'h4, 4'h0, 4'h4, 4'h4);

    // 5. Sticky flag: set wins over a held clear, then clear masks it.
    mode  = 8'h40;
    clear = 4'h8;
    run_edge("ch3_set", 4'h8, 4'h0, 4'h8, 4'h8, 4'hC);
    clear = 4'h0;
    tick(1);
    check("ch3_hold", 32'(flags), 32'(4'hC));
    clear = 4'h8;
    tick(1);
    check("ch3_clear", 32'(flags), 32'(4'h4));
    clear = 4'h0;

    // 6. Reset at E0+3 of a channel-0 rise discards the partial count.
    mode = 8'h41;
    in   = 4'h9;
    tick(3);
    reset_n = 1'b0;
    tick(1);
    check("midrst.level", 32'(level), 32'(0));
    check("midrst.flags", 32'(flags), 32'(0));
    tick(2);
    check("midrst.out", 32'(out), 32'(0));
    check("midrst.level_hold", 32'(level), 32'(0));
    reset_n = 1'b1;
    run_edge("midrst_requal", 4'h9, 4'h0, 4'h9, 4'h9, 4'h9);
    tick(1);
    check("midrst_requal.pulse_end", 32'(out), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
